// File: rtl/mul8b.sv
// Combinational 8x8 unsigned multiplier; the product is always exact in 16 bits.
module mul8b (
   input  logic [7:0]  a_i,
   input  logic [7:0]  b_i,
   output logic [15:0] p_o
);

   assign p_o = a_i * b_i;

endmodule

// File: rtl/mac8b_acc.sv
// Three-stage multiply-accumulate: register operands, register mul8b product, add into a
// wrapping accumulator with a sticky carry flag; result held until the consumer takes it.
module mac8b_acc #(
   parameter int unsigned ACC_W = 24
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [7:0]       len,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       ina,
   input  logic [7:0]       inb,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out,
   output logic             ovf,
   output logic             busy
);

   typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

   state_e           state_q, state_d;
   logic [7:0]       cnt_q, cnt_d;
   logic [7:0]       opa_q, opa_d;
   logic [7:0]       opb_q, opb_d;
   logic             v1_q, v1_d;
   logic [15:0]      p_q, p_d;
   logic             v2_q, v2_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic             ovf_q, ovf_d;

   logic [15:0]      prod;
   logic [ACC_W:0]   sum;
   logic             fire;

   mul8b u_mul8b (
      .a_i (opa_q),
      .b_i (opb_q),
      .p_o (prod)
   );

   assign in_ready  = (state_q == StRun);
   assign fire      = in_valid & in_ready;
   // One extra bit captures the wrap-around carry for the sticky flag.
   assign sum       = {1'b0, acc_q} + (ACC_W + 1)'(p_q);
   assign out_valid = (state_q == StDone);
   assign busy      = (state_q != StIdle);
   assign out       = acc_q;
   assign ovf       = ovf_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      opa_d   = opa_q;
      opb_d   = opb_q;
      v1_d    = 1'b0;
      p_d     = v1_q ? prod : p_q;
      v2_d    = v1_q;
      acc_d   = acc_q;
      ovf_d   = ovf_q;

      if (fire) begin
         opa_d = ina;
         opb_d = inb;
         v1_d  = 1'b1;
         cnt_d = cnt_q - 8'd1;
      end

      if (v2_q) begin
         acc_d = sum[ACC_W-1:0];
         ovf_d = ovf_q | sum[ACC_W];
      end

      unique case (state_q)
         StIdle: begin
            if (start) begin
               acc_d   = '0;
               ovf_d   = 1'b0;
               cnt_d   = len;
               state_d = (len != 8'd0) ? StRun : StDone;
            end
         end
         StRun: begin
            if (fire && (cnt_q == 8'd1)) state_d = StDrain;
         end
         // Only S3 can still be busy once S1 is empty; it retires on this same edge.
         StDrain: begin
            if (!v1_q) state_d = StDone;
         end
         StDone: begin
            if (out_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         opa_q   <= '0;
         opb_q   <= '0;
         v1_q    <= 1'b0;
         p_q     <= '0;
         v2_q    <= 1'b0;
         acc_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         v1_q    <= v1_d;
         p_q     <= p_d;
         v2_q    <= v2_d;
         acc_q   <= acc_d;
         ovf_q   <= ovf_d;
      end
   end

endmodule

// File: tb/tb_mac8b_acc.sv
// Directed bench for mac8b_acc: default 24-bit accumulator plus a 16-bit copy for wrap tests.
module tb_mac8b_acc;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [7:0]  len;
   logic        in_valid;
   logic [7:0]  ina;
   logic [7:0]  inb;
   logic        out_ready;

   logic        in_ready, out_valid, ovf, busy;
   logic [23:0] out;
   logic        in_ready16, out_valid16, ovf16, busy16;
   logic [15:0] out16;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   mac8b_acc #(.ACC_W(24)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .len       (len),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .ina       (ina),
      .inb       (inb),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out       (out),
      .ovf       (ovf),
      .busy      (busy)
   );

   mac8b_acc #(.ACC_W(16)) dut16 (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .len       (len),
      .in_valid  (in_valid),
      .in_ready  (in_ready16),
      .ina       (ina),
      .inb       (inb),
      .out_valid (out_valid16),
      .out_ready (out_ready),
      .out       (out16),
      .ovf       (ovf16),
      .busy      (busy16)
   );

   // Advance one cycle; inputs driven and outputs sampled 1 time unit after the edge.
   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic start_run(input logic [7:0] n);
      start = 1'b1;
      len   = n;
      step();
      start = 1'b0;
   endtask

   task automatic release_result;
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   task automatic test_reset;
      start_run(8'd4);
      in_valid = 1'b1; ina = 8'd10; inb = 8'd10;
      step();
      step();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      in_valid = 1'b0;
      checks++; if (busy !== 1'b0) begin errors++;
         $display("FAIL reset_busy: got %0b want 0", busy); end
      checks++; if (in_ready !== 1'b0) begin errors++;
         $display("FAIL reset_in_ready: got %0b want 0", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++;
         $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
      checks++; if (out !== 24'd0) begin errors++;
         $display("FAIL reset_out: got %0d want 0", out); end
      checks++; if (ovf !== 1'b0) begin errors++;
         $display("FAIL reset_ovf: got %0b want 0", ovf); end
      start_run(8'd1);
      in_valid = 1'b1; ina = 8'd2; inb = 8'd3;
      step();
      in_valid = 1'b0;
      step();
      step();
      checks++; if (out_valid !== 1'b1) begin errors++;
         $display("FAIL post_reset_valid: got %0b want 1", out_valid); end
      checks++; if (out !== 24'd6) begin errors++;
         $display("FAIL post_reset_out: got %0d want 6", out); end
      release_result();
      checks++; if (busy !== 1'b0) begin errors++;
         $display("FAIL post_reset_idle: busy got %0b want 0", busy); end
   endtask

   task automatic test_back_to_back;
      start_run(8'd3);
      checks++; if (in_ready !== 1'b1) begin errors++;
         $display("FAIL b2b_ready_t: got %0b want 1", in_ready); end
      in_valid = 1'b1; ina = 8'd255; inb = 8'd255;
      step();
      ina = 8'd16; inb = 8'd16;
      step();
      ina = 8'd0; inb = 8'd200;
      step();
      in_valid = 1'b0;
      checks++; if (in_ready !== 1'b0) begin errors++;
         $display("FAIL b2b_ready_t3: got %0b want 0", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++;
         $display("FAIL b2b_early_t3: got %0b want 0", out_valid); end
      step();
      checks++; if (out_valid !== 1'b0) begin errors++;
         $display("FAIL b2b_early_t4: got %0b want 0", out_valid); end
      step();
      checks++; if (out_valid !== 1'b1) begin errors++;
         $display("FAIL b2b_valid_t5: got %0b want 1", out_valid); end
      checks++; if (out !== 24'h00FF01) begin errors++;
         $display("FAIL b2b_out: got %0d want 65281", out); end
      checks++; if (ovf !== 1'b0) begin errors++;
         $display("FAIL b2b_ovf: got %0b want 0", ovf); end
      release_result();
   endtask

   task automatic test_gapped;
      start_run(8'd2);
      in_valid = 1'b1; ina = 8'd3; inb = 8'd5;
      step();
      in_valid = 1'b0; ina = 8'd99; inb = 8'd99;
      step();
      step();
      in_valid = 1'b1; ina = 8'd7; inb = 8'd9;
      checks++; if (in_ready !== 1'b1) begin errors++;
         $display("FAIL gap_still_run: got %0b want 1", in_ready); end
      step();
      in_valid = 1'b0;
      checks++; if (in_ready !== 1'b0) begin errors++;
         $display("FAIL gap_drain: got %0b want 0", in_ready); end
      step();
      checks++; if (out_valid !== 1'b0) begin errors++;
         $display("FAIL gap_early: got %0b want 0", out_valid); end
      step();
      checks++; if (out_valid !== 1'b1) begin errors++;
         $display("FAIL gap_valid: got %0b want 1", out_valid); end
      checks++; if (out !== 24'd78) begin errors++;
         $display("FAIL gap_out: got %0d want 78", out); end
      release_result();
   endtask

   task automatic test_len0;
      start = 1'b1; len = 8'd0;
      in_valid = 1'b1; ina = 8'd50; inb = 8'd50;
      step();
      start = 1'b0;
      checks++; if (out_valid !== 1'b1) begin errors++;
         $display("FAIL len0_valid: got %0b want 1", out_valid); end
      checks++; if (out !== 24'd0) begin errors++;
         $display("FAIL len0_out: got %0d want 0", out); end
      checks++; if (ovf !== 1'b0) begin errors++;
         $display("FAIL len0_ovf: got %0b want 0", ovf); end
      checks++; if (in_ready !== 1'b0) begin errors++;
         $display("FAIL len0_ready: got %0b want 0", in_ready); end
      step();
      step();
      step();
      checks++; if (out !== 24'd0) begin errors++;
         $display("FAIL len0_out_held: got %0d want 0", out); end
      in_valid = 1'b0;
      release_result();
      checks++; if (busy !== 1'b0) begin errors++;
         $display("FAIL len0_idle: busy got %0b want 0", busy); end
   endtask

   task automatic test_wrap16;
      int n;
      start_run(8'd2);
      in_valid = 1'b1; ina = 8'd255; inb = 8'd255;
      step();
      step();
      in_valid = 1'b0;
      n = 0;
      while (out_valid16 !== 1'b1 && n < 10) begin
         step();
         n++;
      end
      checks++; if (out_valid16 !== 1'b1) begin errors++;
         $display("FAIL wrap_valid: got %0b want 1", out_valid16); end
      checks++; if (out16 !== 16'hFC02) begin errors++;
         $display("FAIL wrap_out16: got %0d want 64514", out16); end
      checks++; if (ovf16 !== 1'b1) begin errors++;
         $display("FAIL wrap_ovf16: got %0b want 1", ovf16); end
      checks++; if (out !== 24'd130050) begin errors++;
         $display("FAIL wide_out: got %0d want 130050", out); end
      checks++; if (ovf !== 1'b0) begin errors++;
         $display("FAIL wide_ovf: got %0b want 0", ovf); end
      release_result();
      start_run(8'd1);
      in_valid = 1'b1; ina = 8'd1; inb = 8'd1;
      step();
      in_valid = 1'b0;
      step();
      step();
      checks++; if (out16 !== 16'd1) begin errors++;
         $display("FAIL wrap_next_out: got %0d want 1", out16); end
      checks++; if (ovf16 !== 1'b0) begin errors++;
         $display("FAIL wrap_next_ovf: got %0b want 0", ovf16); end
      release_result();
   endtask

   task automatic test_hold;
      start_run(8'd1);
      in_valid = 1'b1; ina = 8'd4; inb = 8'd5;
      step();
      in_valid = 1'b0;
      step();
      step();
      for (int i = 0; i < 10; i++) begin
         start = (i % 2 == 0); len = 8'd5; in_valid = 1'b1;
         step();
         checks++; if (out_valid !== 1'b1 || out !== 24'd20 || ovf !== 1'b0) begin errors++;
            $display("FAIL hold_%0d: got valid=%0b out=%0d ovf=%0b want 1/20/0",
                     i, out_valid, out, ovf); end
         checks++; if (in_ready !== 1'b0) begin errors++;
            $display("FAIL hold_ready_%0d: got %0b want 0", i, in_ready); end
      end
      in_valid = 1'b0;
      start = 1'b1; len = 8'd1;
      release_result();
      start = 1'b0;
      checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin errors++;
         $display("FAIL hold_release: got busy=%0b valid=%0b want 0/0", busy, out_valid); end
      checks++; if (out !== 24'd20) begin errors++;
         $display("FAIL hold_retain: got %0d want 20", out); end
      start_run(8'd1);
      checks++; if (in_ready !== 1'b1) begin errors++;
         $display("FAIL hold_restart: got %0b want 1", in_ready); end
      in_valid = 1'b1; ina = 8'd6; inb = 8'd7;
      step();
      in_valid = 1'b0;
      step();
      step();
      checks++; if (out_valid !== 1'b1 || out !== 24'd42) begin errors++;
         $display("FAIL hold_next_run: got valid=%0b out=%0d want 1/42", out_valid, out); end
      release_result();
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; len = 8'd0; in_valid = 1'b0;
      ina = 8'd0; inb = 8'd0; out_ready = 1'b0;
      step();
      step();
      rst = 1'b0;
      step();
      test_reset();
      test_back_to_back();
      test_gapped();
      test_len0();
      test_wrap16();
      test_hold();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
